// File: rtl/acc_in_streamer.sv
// acc_in_streamer
// ---------------------------------------------------------------------------
// Upstream feeder for the conv accelerator. On a start pulse it latches a base
// word address and a word count. It then reads that many consecutive words
// from a one-cycle-latency memory port and hands them to the accelerator as a
// data/valid stream. Reads are spaced one word every GAP cycles.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle launch pulse (only honoured in IDLE)
//   base_addr         first word address (latched on accepted start)
//   word_cnt          number of words (latched on accepted start)
//   pause             downstream stall; blocks issuing new reads
//   mem_rd, mem_addr  memory read strobe and word address
//   mem_rdata         memory read data, valid the cycle after mem_rd
//   data_o, valid_o   streamed word and its one-cycle qualifier
//   bus_free          memory bus not used this cycle (== !mem_rd)
//   busy, done        transfer in progress / one-cycle end-of-transfer pulse
// ---------------------------------------------------------------------------
module acc_in_streamer #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32,
    parameter int GAP    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_cnt,
    input  logic              pause,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              bus_free,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] LAST_PHASE = 4'(GAP - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rem;
    logic [3:0]        phase;
    logic              valid_q;
    logic [DATA_W-1:0] data_hold;
    logic              issue;

    // A read goes out only at phase 0 with words left. Pause is applied
    // combinationally so that a stall request suppresses the strobe in the
    // same cycle it is raised.
    assign issue = (state == RUN) && (phase == 4'd0) && (rem != '0) && !pause;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            rem       <= '0;
            phase     <= 4'd0;
            valid_q   <= 1'b0;
            data_hold <= '0;
        end else begin
            valid_q <= issue;
            if (valid_q) begin
                data_hold <= mem_rdata;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (word_cnt != '0) begin
                            state <= RUN;
                            addr  <= base_addr;
                            rem   <= word_cnt;
                            phase <= 4'd0;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    // The last word is on the stream this cycle, so the
                    // transfer ends here. For GAP >= 2 this always happens
                    // at phase 1, which means it never races a new issue.
                    if (valid_q && (rem == '0)) begin
                        state <= DONE;
                        phase <= 4'd0;
                    end else if (phase == 4'd0) begin
                        if (issue) begin
                            addr  <= addr + ADDR_W'(1);
                            rem   <= rem - ADDR_W'(1);
                            phase <= 4'd1;
                        end
                    end else if (phase == LAST_PHASE) begin
                        phase <= 4'd0;
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The memory returns data in the same cycle valid_o is high. That word is
    // passed straight through during the valid cycle and is then held from
    // the capture register until the next word arrives.
    assign data_o   = valid_q ? mem_rdata : data_hold;
    assign valid_o  = valid_q;
    assign mem_rd   = issue;
    assign mem_addr = addr;
    assign bus_free = !issue;
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_acc_in_streamer.sv
// tb_acc_in_streamer
// ---------------------------------------------------------------------------
// Directed bench for acc_in_streamer. Each transfer derives its expected read
// cycles from the pacing rule: the first read comes one cycle after
// acceptance, and each later read comes GAP cycles after the previous one,
// slipping past any cycles where pause is high. Addresses and data words are
// pushed into scoreboard queues. A monitor pops an entry each time the DUT
// strobes mem_rd or valid_o and compares against it.
// ---------------------------------------------------------------------------
module tb_acc_in_streamer;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 32;
    localparam int GAP    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] word_cnt = '0;
    logic              pause = 1'b0;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              bus_free;
    logic              busy;
    logic              done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [ADDR_W-1:0] addr_q[$];
    logic [DATA_W-1:0] data_q[$];
    logic [DATA_W-1:0] mem_arr[logic [ADDR_W-1:0]];

    acc_in_streamer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .pause(pause), .mem_rd(mem_rd),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .data_o(data_o),
        .valid_o(valid_o), .bus_free(bus_free), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] memval(input logic [ADDR_W-1:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {12'hC0D, a};
    endfunction

    // Memory model with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= memval(mem_addr);
    end

    task automatic check_output(input string tag, input logic [DATA_W-1:0] obs,
                                input logic [DATA_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: sampled 1 time unit after each falling edge.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (mem_rd) begin
                if (addr_q.size() == 0) begin
                    n_assert++; n_fail++;
                    $error("FAIL sb.addr: observed read of 0x%0h expected no read", mem_addr);
                end else begin
                    check_output("sb.addr", DATA_W'(mem_addr), DATA_W'(addr_q.pop_front()));
                end
            end
            if (valid_o) begin
                if (data_q.size() == 0) begin
                    n_assert++; n_fail++;
                    $error("FAIL sb.data: observed word 0x%0h expected no word", data_o);
                end else begin
                    check_output("sb.data", data_o, data_q.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_output({tag, ".mem_rd"},   DATA_W'(mem_rd),   0);
        check_output({tag, ".mem_addr"}, DATA_W'(mem_addr), 0);
        check_output({tag, ".data_o"},   data_o,            0);
        check_output({tag, ".valid_o"},  DATA_W'(valid_o),  0);
        check_output({tag, ".bus_free"}, DATA_W'(bus_free), 1);
        check_output({tag, ".busy"},     DATA_W'(busy),     0);
        check_output({tag, ".done"},     DATA_W'(done),     0);
    endtask

    // One complete transfer. Cycle 1 is the cycle after the accepting edge.
    // Pause is high for cycles p_lo..p_hi. A competing start is pulsed in
    // cycle mid_start when that value is nonzero.
    task automatic run_transfer(input string tag, input logic [ADDR_W-1:0] base,
                                input logic [ADDR_W-1:0] cnt, input int p_lo,
                                input int p_hi, input int mid_start);
        int reads[$];
        int c;
        int done_c;
        logic is_rd, is_val;
        logic [DATA_W-1:0] last_word;
        c = 1;
        last_word = '0;
        for (int k = 0; k < int'(cnt); k++) begin
            while (c >= p_lo && c <= p_hi) c++;
            reads.push_back(c);
            addr_q.push_back(base + ADDR_W'(k));
            data_q.push_back(memval(base + ADDR_W'(k)));
            last_word = memval(base + ADDR_W'(k));
            c += GAP;
        end
        done_c = (cnt == 0) ? 1 : reads[$] + 2;

        @(negedge clk);
        start = 1'b1; base_addr = base; word_cnt = cnt; pause = 1'b0;
        for (int cy = 1; cy <= done_c + 1; cy++) begin
            @(negedge clk);
            start = (cy == mid_start);
            base_addr = base ^ 20'h55555;
            word_cnt = cnt + ADDR_W'(3);
            pause = (cy >= p_lo && cy <= p_hi);
            #1;
            is_rd = 1'b0; is_val = 1'b0;
            foreach (reads[i]) begin
                if (reads[i] == cy) is_rd = 1'b1;
                if (reads[i] == cy - 1) is_val = 1'b1;
            end
            check_output({tag, ".mem_rd"},   DATA_W'(mem_rd),   DATA_W'(is_rd));
            check_output({tag, ".bus_free"}, DATA_W'(bus_free), DATA_W'(!is_rd));
            check_output({tag, ".valid_o"},  DATA_W'(valid_o),  DATA_W'(is_val));
            check_output({tag, ".busy"},     DATA_W'(busy),     DATA_W'(cy < done_c));
            check_output({tag, ".done"},     DATA_W'(done),     DATA_W'(cy == done_c));
            if (cnt != 0 && cy == done_c)
                check_output({tag, ".data_hold"}, data_o, last_word);
        end
        start = 1'b0; pause = 1'b0;
        check_output({tag, ".addr_q_empty"}, DATA_W'(addr_q.size()), 0);
        check_output({tag, ".data_q_empty"}, DATA_W'(data_q.size()), 0);
    endtask

    initial begin
        mem_arr[20'h00010] = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) mem_arr[ADDR_W'(i)] = 32'h100 + i;

        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("idle");

        run_transfer("single",  20'h00010, 20'd1, 0, -1, 0);
        run_transfer("cadence", 20'h00000, 20'd4, 0, -1, 0);
        run_transfer("pause",   20'h00000, 20'd4, 4, 8, 0);
        run_transfer("zero",    20'h00040, 20'd0, 0, -1, 0);
        run_transfer("ign_start", 20'h00000, 20'd4, 0, -1, 3);
        run_transfer("wrap",    20'hFFFFE, 20'd4, 0, -1, 0);

        // Reset in the middle of a 4-word transfer, right after word 1.
        for (int k = 0; k < 4; k++) begin
            addr_q.push_back(20'h00200 + ADDR_W'(k));
            data_q.push_back(memval(20'h00200 + ADDR_W'(k)));
        end
        @(negedge clk);
        start = 1'b1; base_addr = 20'h00200; word_cnt = 20'd4;
        for (int cy = 1; cy <= 5; cy++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            check_output("mid.valid_o", DATA_W'(valid_o), DATA_W'(cy == 2 || cy == 5));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        addr_q.delete();
        data_q.delete();
        for (int cy = 0; cy < 3; cy++) begin
            @(negedge clk);
            #1;
            check_reset_outputs("in_rst");
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("post_rst_idle");
        run_transfer("post_rst", 20'h00010, 20'd1, 0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
